ram_gen: RTL and testbench

RAM_GEN -- requirements
Module: ram_gen

---
 rtl/hack_pkg.sv | 16 +
 rtl/ram_gen_array.sv | 39 +++
 rtl/ram_gen.sv | 149 ++++++++++++++
 tb/tb_ram_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared constants and types for the ram_gen storage block.
//   WORD_W       - default data word width
//   RDW_OLD/NEW  - read-during-write mode selectors (old data / new data)
//   ram_state_e  - two-state controller encoding (clear engine running / idle)
package hack_pkg;

   localparam int unsigned WORD_W  = 16;
   localparam int unsigned RDW_OLD = 0;
   localparam int unsigned RDW_NEW = 1;

   typedef enum logic {
      StClear = 1'b0,
      StIdle  = 1'b1
   } ram_state_e;

endpackage

// File: rtl/ram_gen_array.sv
// ram_gen_array: single-port storage, synchronous write, no reset.
// The read port is combinational; the owning block registers the result, which
// keeps the output register (and its reset value) in one place.
//   clk   - write clock (rising edge)
//   we    - write enable
//   addr  - shared read/write address (must be < DEPTH when we = 1)
//   wdata - write word
//   rdata - read word; in RDW_NEW mode a concurrent write is bypassed to it
module ram_gen_array
   import hack_pkg::*;
#(
   parameter int unsigned WIDTH    = WORD_W,
   parameter int unsigned DEPTH    = 16384,
   parameter int unsigned RDW_MODE = RDW_OLD,
   localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   always_comb begin
      rdata = mem[addr];
      if ((RDW_MODE == RDW_NEW) && we) begin
         rdata = wdata;
      end
   end

endmodule

// File: rtl/ram_gen.sv
// ram_gen: word-addressed RAM with a self-running clear engine.
// After reset (or a clear request) every word is written with CLEAR_VAL, one word
// per cycle, while ready = 0. In IDLE every cycle is a read with 1-cycle latency
// and load writes data at address.
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   data       - write data
//   load       - write enable (ignored while ready = 0)
//   address    - read/write address; addresses >= DEPTH read CLEAR_VAL
//   clear      - request a full re-initialisation
//   out        - registered read data (holds while ready = 0)
//   out_valid  - out holds a valid user read
//   ready      - user accesses accepted
//   parity_err - read word failed its even-parity check (RAM_GEN_PARITY_EN only)
// Optional feature: define RAM_GEN_PARITY_EN to store one even-parity bit per word.
module ram_gen
   import hack_pkg::*;
#(
   parameter int unsigned      WIDTH     = WORD_W,
   parameter int unsigned      DEPTH     = 16384,
   parameter int unsigned      RDW_MODE  = RDW_OLD,
   parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
   localparam int unsigned     ADDR_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  data,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic              clear,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              ready
`ifdef RAM_GEN_PARITY_EN
   ,
   output logic              parity_err
`endif
);

`ifdef RAM_GEN_PARITY_EN
   localparam int unsigned MEM_W = WIDTH + 1;
`else
   localparam int unsigned MEM_W = WIDTH;
`endif

   ram_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic              out_valid_q, out_valid_d;

   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [WIDTH-1:0]  arr_data;
   logic [MEM_W-1:0]  arr_wword;
   logic [MEM_W-1:0]  arr_rword;
   logic              in_range;

   // Extra bit on the left so a power-of-two DEPTH compares correctly.
   assign in_range = {1'b0, address} < (ADDR_W + 1)'(DEPTH);

`ifdef RAM_GEN_PARITY_EN
   logic parity_err_q, parity_err_d;
   // Even parity: stored bit makes the total number of ones even.
   assign arr_wword = {^arr_data, arr_data};
`else
   assign arr_wword = arr_data;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      arr_we      = 1'b0;
      arr_addr    = address;
      arr_data    = data;
      unique case (state_q)
         StClear: begin
            arr_we   = 1'b1;
            arr_addr = cnt_q;
            arr_data = CLEAR_VAL;
            if (clear) begin
               cnt_d = '0;
            end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StIdle: begin
            arr_we = load & in_range;
            out_d  = in_range ? arr_rword[WIDTH-1:0] : CLEAR_VAL;
            // A read issued together with clear still updates out, but the next
            // cycle is already CLEAR, where out_valid must stay low.
            out_valid_d = ~clear;
            if (clear) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         default: state_d = StClear;
      endcase
   end

`ifdef RAM_GEN_PARITY_EN
   assign parity_err_d = out_valid_d & in_range & (^arr_rword);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StClear;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef RAM_GEN_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
`ifdef RAM_GEN_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   ram_gen_array #(
      .WIDTH    (MEM_W),
      .DEPTH    (DEPTH),
      .RDW_MODE (RDW_MODE)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .addr  (arr_addr),
      .wdata (arr_wword),
      .rdata (arr_rword)
   );

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign ready     = (state_q == StIdle);
`ifdef RAM_GEN_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_ram_gen.sv
// tb_ram_gen: three ram_gen instances share one stimulus stream:
//   0: DEPTH 8, read-first     1: DEPTH 8, write-first
//   2: DEPTH 5, read-first, CLEAR_VAL 0x5A5A (exercises out-of-range addresses)
// A behavioural model tracks memory contents, the remaining clear length and the
// expected registered outputs of each instance.
module tb_ram_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] data = '0;
   logic [2:0]  address = '0;

   logic [15:0] dout [3];
   logic        dval [3];
   logic        drdy [3];
`ifdef RAM_GEN_PARITY_EN
   logic        perr [3];
`endif

   int unsigned depth_c [3] = '{8, 8, 5};
   bit          rdw_c   [3] = '{1'b0, 1'b1, 1'b0};
   logic [15:0] cv_c    [3] = '{16'h0000, 16'h0000, 16'h5A5A};

   logic [15:0] m_mem  [3][8];
   int          m_left [3];
   logic [15:0] m_out  [3];
   bit          m_val  [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ram_gen #(.WIDTH(16), .DEPTH(8), .RDW_MODE(0)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .address(address),
      .clear(clear), .out(dout[0]), .out_valid(dval[0]), .ready(drdy[0])
`ifdef RAM_GEN_PARITY_EN
      , .parity_err(perr[0])
`endif
   );

   ram_gen #(.WIDTH(16), .DEPTH(8), .RDW_MODE(1)) u_dut8n (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .address(address),
      .clear(clear), .out(dout[1]), .out_valid(dval[1]), .ready(drdy[1])
`ifdef RAM_GEN_PARITY_EN
      , .parity_err(perr[1])
`endif
   );

   ram_gen #(.WIDTH(16), .DEPTH(5), .RDW_MODE(0), .CLEAR_VAL(16'h5A5A)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .data(data), .load(load), .address(address),
      .clear(clear), .out(dout[2]), .out_valid(dval[2]), .ready(drdy[2])
`ifdef RAM_GEN_PARITY_EN
      , .parity_err(perr[2])
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_left[k] = int'(depth_c[k]);
         m_out[k]  = '0;
         m_val[k]  = 1'b0;
      end
   endtask

   // One clock edge of the model: a clear of length DEPTH writes word
   // (DEPTH - remaining) each cycle; idle cycles read and optionally write.
   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         if (m_left[k] == 0) begin
            bit          inr;
            logic [15:0] rd;
            inr = (int'(address) < int'(depth_c[k]));
            if (!inr)                  rd = cv_c[k];
            else if (load && rdw_c[k]) rd = data;
            else                       rd = m_mem[k][address];
            if (load && inr) m_mem[k][address] = data;
            m_out[k] = rd;
            m_val[k] = !clear;
            if (clear) m_left[k] = int'(depth_c[k]);
         end else begin
            m_mem[k][int'(depth_c[k]) - m_left[k]] = cv_c[k];
            m_val[k] = 1'b0;
            m_left[k] = clear ? int'(depth_c[k]) : m_left[k] - 1;
         end
      end
   endtask

   // Compare process: after every clock edge or reset assertion.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("out[%0d]", k), {16'h0, dout[k]}, {16'h0, m_out[k]});
            chk($sformatf("out_valid[%0d]", k), {31'h0, dval[k]}, {31'h0, m_val[k]});
            chk($sformatf("ready[%0d]", k), {31'h0, drdy[k]}, {31'h0, m_left[k] == 0});
         end
      end
   end

   task automatic drive(input bit ld, input logic [2:0] a, input logic [15:0] d,
                        input bit clr);
      @(negedge clk);
      load    = ld;
      address = a;
      data    = d;
      clear   = clr;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Called at a negedge with idle inputs; counts cycles with ready = 0.
   task automatic wait_ready(output int n);
      n = 0;
      while (!drdy[0] && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset_ready", {31'h0, drdy[0]}, 32'h0);
      chk("reset_out", {16'h0, dout[0]}, 32'h0);
      rst_n = 1'b1;
      wait_ready(n);
      chk("clear_len_after_reset", n, 32'd8);

      for (int a = 0; a < 8; a++) begin
         drive(1'b0, a[2:0], 16'h0, 1'b0);
         settle();
         chk("initial_read", {16'h0, dout[0]}, 32'h0);
         chk("initial_valid", {31'h0, dval[0]}, 32'h1);
      end

      drive(1'b1, 3'd0, 16'h0003, 1'b0);
      drive(1'b0, 3'd0, 16'h0000, 1'b0);
      settle();
      chk("write_then_read", {16'h0, dout[0]}, 32'h0003);
      drive(1'b1, 3'd0, 16'hE7D0, 1'b0);
      settle();
      chk("rdw_old", {16'h0, dout[0]}, 32'h0003);
      chk("rdw_new", {16'h0, dout[1]}, 32'hE7D0);

      drive(1'b1, 3'd1, 16'h1111, 1'b0);
      drive(1'b1, 3'd6, 16'h1234, 1'b0);
      drive(1'b0, 3'd6, 16'h0000, 1'b0);
      settle();
      chk("depth5_oob_read", {16'h0, dout[2]}, 32'h5A5A);
      chk("depth8_addr6", {16'h0, dout[0]}, 32'h1234);
      drive(1'b0, 3'd1, 16'h0000, 1'b0);
      settle();
      chk("depth5_addr1_kept", {16'h0, dout[2]}, 32'h1111);

      for (int a = 0; a < 8; a++) drive(1'b1, a[2:0], 16'hAAAA, 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (drdy[0]) break;
         n++;
         load    = 1'b1;
         address = 3'(i);
         data    = 16'hFFFF;
         clear   = 1'b0;
      end
      load = 1'b0;
      chk("clear_len_after_pulse", n, 32'd8);
      for (int a = 0; a < 8; a++) begin
         drive(1'b0, a[2:0], 16'h0, 1'b0);
         settle();
         chk("after_clear_read", {16'h0, dout[0]}, 32'h0);
      end

      drive(1'b1, 3'd7, 16'h0005, 1'b0);
      drive(1'b0, 3'd7, 16'h0000, 1'b0);
      settle();
      chk("pre_reset_out", {16'h0, dout[0]}, 32'h0005);
      drive(1'b0, 3'd0, 16'h0, 1'b1);
      drive(1'b0, 3'd0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midclear_reset_out", {16'h0, dout[0]}, 32'h0);
      chk("midclear_reset_valid", {31'h0, dval[0]}, 32'h0);
      chk("midclear_reset_ready", {31'h0, drdy[0]}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n);
      chk("clear_len_after_midreset", n, 32'd8);

      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 3'($urandom), 16'($urandom), $urandom_range(0, 39) == 0);
      end
      drive(1'b0, 3'd0, 16'h0, 1'b0);
      wait_ready(n);

`ifdef RAM_GEN_PARITY_EN
      @(negedge clk);
      u_dut8.u_array.mem[2][16] = ~u_dut8.u_array.mem[2][16];
      drive(1'b0, 3'd2, 16'h0, 1'b0);
      settle();
      chk("parity_err_flipped", {31'h0, perr[0]}, 32'h1);
      chk("parity_valid_flipped", {31'h0, dval[0]}, 32'h1);
      drive(1'b0, 3'd3, 16'h0, 1'b0);
      settle();
      chk("parity_err_clean", {31'h0, perr[0]}, 32'h0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
